// File: rtl/seq_gen.sv
// Parallel-to-serial frame generator: accepts a WIDTH-bit word and emits it MSB first,
// with a valid strobe, a running bit index and a done pulse on the final bit.
module seq_gen #(
    parameter int   WIDTH    = 36,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             done,
    output logic [6:0]       bit_idx
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic             accept;

    // Ready also in the last-bit cycle so a new frame can follow with no gap.
    assign ready  = (state == IDLE) || (bit_idx == 7'd0);
    assign accept = load && ready;

    // The MSB goes straight to dout on accept; shift_reg holds only the bits still to come.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            bit_idx    <= 7'd0;
        end else if (accept) begin
            state      <= SHIFT;
            shift_reg  <= {data[WIDTH-2:0], 1'b0};
            dout       <= data[WIDTH-1];
            dout_valid <= 1'b1;
            done       <= 1'b0;
            bit_idx    <= LAST_IDX;
        end else begin
            case (state)
                SHIFT: begin
                    if (bit_idx == 7'd0) begin
                        state      <= IDLE;
                        dout       <= IDLE_BIT;
                        dout_valid <= 1'b0;
                        done       <= 1'b0;
                    end else begin
                        dout      <= shift_reg[WIDTH-1];
                        shift_reg <= shift_reg << 1;
                        bit_idx   <= bit_idx - 7'd1;
                        done      <= (bit_idx == 7'd1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    dout       <= IDLE_BIT;
                    dout_valid <= 1'b0;
                    done       <= 1'b0;
                    bit_idx    <= 7'd0;
                end
            endcase
        end
    end

endmodule
